nibble_serial_subtractor: RTL and testbench



---
 rtl/nibble_serial_subtractor.sv | 128 ++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// Digit-serial subtractor: Diff = A - B - Bin, one 4-bit digit per clock, LSB digit first,
// with a 4-bit borrow-lookahead block per digit and a valid/ready handshake on each side.
module nibble_serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero,
    output logic             Ovf
);

    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    k;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow;
    logic [4:0]       dig;
    logic [WIDTH-1:0] diff_nx;

    // Returns {borrow_out, diff[3:0]}. bg marks a borrow generated locally (a=0, b=1),
    // p marks equal bits that pass the incoming borrow through unchanged.
    function automatic logic [4:0] sub_digit(input logic [3:0] a, input logic [3:0] b,
                                             input logic bin);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] bg;
        logic [4:0] br;
        g  = a & ~b;
        p  = ~(a ^ b);
        bg = ~g & ~p;
        br[0] = bin;
        br[1] = bg[0] | (p[0] & bin);
        br[2] = bg[1] | (p[1] & bg[0]) | (p[1] & p[0] & bin);
        br[3] = bg[2] | (p[2] & bg[1]) | (p[2] & p[1] & bg[0]) | (p[2] & p[1] & p[0] & bin);
        br[4] = bg[3] | (p[3] & bg[2]) | (p[3] & p[2] & bg[1]) | (p[3] & p[2] & p[1] & bg[0])
              | (p[3] & p[2] & p[1] & p[0] & bin);
        return {br[4], a ^ b ^ br[3:0]};
    endfunction

    always_comb begin
        dig     = sub_digit(a_q[{k, 2'b00} +: 4], b_q[{k, 2'b00} +: 4], borrow);
        diff_nx = Diff;
        diff_nx[{k, 2'b00} +: 4] = dig[3:0];
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (k == LAST) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            k      <= '0;
            borrow <= 1'b0;
            Diff   <= '0;
            Bout   <= 1'b0;
            Zero   <= 1'b0;
            Ovf    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        k      <= '0;
                        borrow <= Bin;
                        Diff   <= '0;
                    end
                end
                RUN: begin
                    Diff   <= diff_nx;
                    borrow <= dig[4];
                    k      <= k + 1'b1;
                    // Flags are taken from the fully assembled difference on the last digit.
                    if (k == LAST) begin
                        Bout <= dig[4];
                        Zero <= (diff_nx == '0);
                        Ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_nx[WIDTH-1] != a_q[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (state == IDLE && in_valid) begin
            a_q <= A;
            b_q <= B;
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor (WIDTH=32): reference results are queued at operand
// accept and compared against the DUT outputs when out_valid is seen.
module tb_nibble_serial_subtractor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] Diff;
    logic        Bout;
    logic        Zero;
    logic        Ovf;

    typedef logic [34:0] res_t;   // {diff, bout, zero, ovf}
    res_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    nibble_serial_subtractor #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
        .Diff(Diff), .Bout(Bout), .Zero(Zero), .Ovf(Ovf)
    );

    always #5 clock = ~clock;

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [32:0] r;
        logic [31:0] d;
        r = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        d = r[31:0];
        return {d, r[32], (d == 32'd0), (a[31] != b[31]) && (d[31] != a[31])};
    endfunction

    // Presents operands for exactly one accept edge and queues the expected result.
    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic bin);
        A = a; B = b; Bin = bin; in_valid = 1'b1;
        sb.push_back(model(a, b, bin));
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_result(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    function automatic res_t pop_expected();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; A = 32'hDEAD_BEEF; B = 32'h1;
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if ({in_ready, out_valid, Diff, Bout, Zero, Ovf} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_values: got rdy=%b vld=%b diff=%h flags=%b%b%b, want rdy=1 vld=0 diff=0 flags=000",
                     in_ready, out_valid, Diff, Bout, Zero, Ovf);
        end
        in_valid = 1'b0; reset = 1'b0;
        @(posedge clock); #1;
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_release_idle: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        logic [31:0] ta[6] = '{32'h0000_0005, 32'h0000_0000, 32'h8000_0000,
                               32'h7FFF_FFFF, 32'h1234_5678, 32'h1234_5678};
        logic [31:0] tb[6] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001,
                               32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678};
        logic        tc[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int   lat;
        res_t exp;
        for (int i = 0; i < 6; i++) begin
            accept(ta[i], tb[i], tc[i]);
            wait_result(lat);
            vectors++;
            if (lat !== 8) begin
                miscompares++;
                $display("FAIL basic_latency[%0d]: got %0d cycles, want 8", i, lat);
            end
            exp = pop_expected();
            vectors++;
            if ({Diff, Bout, Zero, Ovf} !== exp) begin
                miscompares++;
                $display("FAIL basic_result[%0d]: got diff=%h b=%b z=%b o=%b, want diff=%h b=%b z=%b o=%b",
                         i, Diff, Bout, Zero, Ovf, exp[34:3], exp[2], exp[1], exp[0]);
            end
            out_ready = 1'b1;
            @(posedge clock); #1;
            out_ready = 1'b0;
            vectors++;
            if ({in_ready, out_valid} !== 2'b10) begin
                miscompares++;
                $display("FAIL basic_release[%0d]: got rdy=%b vld=%b, want rdy=1 vld=0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        res_t exp;
        accept(32'hA5A5_0000, 32'h0000_5A5A, 1'b0);
        wait_result(lat);
        exp = pop_expected();
        in_valid = 1'b1; A = 32'h0000_0100; B = 32'h0000_0001; Bin = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            vectors++;
            if ({in_ready, out_valid, Diff, Bout, Zero, Ovf} !== {1'b0, 1'b1, exp}) begin
                miscompares++;
                $display("FAIL hold[%0d]: got rdy=%b vld=%b diff=%h flags=%b%b%b, want rdy=0 vld=1 diff=%h flags=%b",
                         c, in_ready, out_valid, Diff, Bout, Zero, Ovf, exp[34:3], exp[2:0]);
            end
        end
        out_ready = 1'b1;
        sb.push_back(model(32'h0000_0100, 32'h0000_0001, 1'b1));
        @(posedge clock); #1;
        out_ready = 1'b0;
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL hold_exit: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_new_accept: got rdy=%b, want 0", in_ready);
        end
        wait_result(lat);
        exp = pop_expected();
        vectors++;
        if ({lat[5:0], Diff, Bout, Zero, Ovf} !== {6'd8, exp}) begin
            miscompares++;
            $display("FAIL hold_new_result: got lat=%0d diff=%h flags=%b%b%b, want lat=8 diff=%h flags=%b",
                     lat, Diff, Bout, Zero, Ovf, exp[34:3], exp[2:0]);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int   lat;
        res_t exp;
        accept(32'h0000_0005, 32'h0000_0003, 1'b0);
        repeat (3) @(posedge clock);
        #3;
        vectors++;
        if ({out_valid, Diff} !== {1'b0, 32'h0000_0002}) begin
            miscompares++;
            $display("FAIL partial_diff: got vld=%b diff=%h, want vld=0 diff=00000002", out_valid, Diff);
        end
        reset = 1'b1;
        #1;
        sb.delete();
        vectors++;
        if ({in_ready, out_valid, Diff, Bout, Zero, Ovf} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL async_reset: got rdy=%b vld=%b diff=%h flags=%b%b%b, want rdy=1 vld=0 diff=0 flags=000",
                     in_ready, out_valid, Diff, Bout, Zero, Ovf);
        end
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        accept(32'h0000_0005, 32'h0000_0003, 1'b0);
        wait_result(lat);
        exp = pop_expected();
        vectors++;
        if ({lat[5:0], Diff, Bout, Zero, Ovf} !== {6'd8, exp}) begin
            miscompares++;
            $display("FAIL rerun_after_reset: got lat=%0d diff=%h flags=%b%b%b, want lat=8 diff=%h flags=%b",
                     lat, Diff, Bout, Zero, Ovf, exp[34:3], exp[2:0]);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int          lat;
        res_t        exp;
        logic [31:0] ra;
        logic [31:0] rb;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? ra : $urandom;
            accept(ra, rb, 1'($urandom_range(0, 1)));
            wait_result(lat);
            exp = pop_expected();
            vectors++;
            if ({lat[5:0], Diff, Bout, Zero, Ovf} !== {6'd8, exp}) begin
                miscompares++;
                $display("FAIL b2b[%0d]: A=%h B=%h got lat=%0d diff=%h flags=%b%b%b, want lat=8 diff=%h flags=%b",
                         i, ra, rb, lat, Diff, Bout, Zero, Ovf, exp[34:3], exp[2:0]);
            end
            @(posedge clock); #1;
            vectors++;
            if ({in_ready, out_valid} !== 2'b10) begin
                miscompares++;
                $display("FAIL b2b_consume[%0d]: got rdy=%b vld=%b, want rdy=1 vld=0", i, in_ready, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
